// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: sync/deglitch, 11-bit deframe, E0/F0 prefix folding, show-ahead scan-code FIFO.
// Optional macro PS2_TIMEOUT_EN aborts a stalled frame after TIMEOUT_CYC clocks without a strobe.

module ps2_line_filt #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      // cnt tracks how many consecutive samples have disagreed with filt
      if (sync[1] != filt) begin
        if (cnt == CW'(FILT_LEN-1)) begin
          filt <= sync[1];
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module ps2_kbd_rx_fifo #(
  parameter int FILT_LEN    = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en_i,
  input  logic       clr_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       ext_o,
  output logic       break_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, CHECK} st_t;
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_ent_t;

  logic [1:0] raw, filt;
  assign raw = {ps2_data, ps2_clk};

  ps2_line_filt #(.FILT_LEN(FILT_LEN)) u_filt [1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw),
    .filt (filt)
  );

  logic clk_q, strobe, dat;
  assign strobe = clk_q & ~filt[0];
  assign dat    = filt[1];

  st_t        state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_b, stop_b, ext_f, brk_f;
  logic       par_ok, is_pfx, push;

  assign par_ok = ^{shreg, par_b};
  assign is_pfx = (shreg == 8'hE0) || (shreg == 8'hF0);
  assign push   = (state == CHECK) && par_ok && stop_b && !is_pfx;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      clk_q        <= 1'b1;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_b        <= 1'b0;
      stop_b       <= 1'b0;
      ext_f        <= 1'b0;
      brk_f        <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt       <= '0;
`endif
    end else begin
      clk_q        <= filt[0];
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (state)
        IDLE: if (strobe && !dat) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: if (strobe) begin
          shreg   <= {dat, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PAR;
        end
        PAR: if (strobe) begin
          par_b <= dat;
          state <= STOP;
        end
        STOP: if (strobe) begin
          stop_b <= dat;
          state  <= CHECK;
        end
        CHECK: begin
          state <= IDLE;
          if (!par_ok) begin
            parity_err_o <= 1'b1;
            ext_f        <= 1'b0;
            brk_f        <= 1'b0;
          end else if (!stop_b) begin
            frame_err_o <= 1'b1;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
          end else if (shreg == 8'hE0) begin
            ext_f <= 1'b1;
          end else if (shreg == 8'hF0) begin
            brk_f <= 1'b1;
          end else begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef PS2_TIMEOUT_EN
      // only fires without a strobe, so it never fights the case above
      if (state == DATA || state == PAR || state == STOP) begin
        if (strobe) begin
          to_cnt <= '0;
        end else if (to_cnt == TW'(TIMEOUT_CYC-1)) begin
          to_cnt      <= '0;
          state       <= IDLE;
          frame_err_o <= 1'b1;
          ext_f       <= 1'b0;
          brk_f       <= 1'b0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

  kbd_ent_t      mem [FIFO_DEPTH];
  kbd_ent_t      head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_en_i && !empty;
  assign do_push = push && (!full || pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= '{ext: ext_f, brk: brk_f, code: shreg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && full && !pop) overflow_o <= 1'b1;
      else if (clr_i)           overflow_o <= 1'b0;
    end
  end

  assign valid_o = !empty;
  assign data_o  = empty ? 8'h00 : head.code;
  assign ext_o   = !empty && head.ext;
  assign break_o = !empty && head.brk;
endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Directed + randomized bench for ps2_kbd_rx_fifo against a queue-based scan-code model.
`timescale 1ns/1ps
module tb_ps2_kbd_rx_fifo;
  localparam int FL = 8;
  localparam int DEPTH = 8;
  localparam int TO = 400;

  logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1, rd_en_i = 0, clr_i = 0;
  logic valid_o, ext_o, break_o, parity_err_o, frame_err_o, overflow_o;
  logic [7:0] data_o;

  ps2_kbd_rx_fifo #(.FILT_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en_i(rd_en_i), .clr_i(clr_i), .valid_o(valid_o), .data_o(data_o),
    .ext_o(ext_o), .break_o(break_o), .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o));

  always #10 clk = ~clk;

  int total = 0, bad = 0;
  int n_perr = 0, n_ferr = 0, exp_perr = 0, exp_ferr = 0;
  bit [9:0] q[$];
  bit m_ext = 0, m_brk = 0, m_ovf = 0;

  always @(negedge clk) begin
    if (parity_err_o) n_perr++;
    if (frame_err_o)  n_ferr++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // Model: prefixes set flags, good non-prefix byte is queued, errors clear flags.
  task automatic model_frame(input bit [7:0] b, input bit bp, input bit bs);
    if (bp) begin exp_perr++; m_ext = 0; m_brk = 0; end
    else if (bs) begin exp_ferr++; m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back({m_ext, m_brk, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_reset();
    q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
  endtask

  task automatic chk_head(input string tag);
    bit [9:0] h;
    h = (q.size() > 0) ? q[0] : 10'h0;
    chk({tag, "_valid"}, valid_o, (q.size() > 0) ? 1 : 0);
    chk({tag, "_data"}, data_o, h[7:0]);
    chk({tag, "_ext"}, ext_o, h[9]);
    chk({tag, "_brk"}, break_o, h[8]);
    chk({tag, "_ovf"}, overflow_o, m_ovf);
    chk({tag, "_perr"}, n_perr, exp_perr);
    chk({tag, "_ferr"}, n_ferr, exp_ferr);
  endtask

  task automatic pop(input string tag);
    rd_en_i = 1; tick(1); rd_en_i = 0;
    if (q.size() > 0) void'(q.pop_front());
    chk_head(tag);
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    ps2_data = b; tick(10);
    ps2_clk = 0; tick(20);
    ps2_clk = 1; tick(10);
    if (glitch) begin
      ps2_clk = 0; tick(FL-1);
      ps2_clk = 1; tick(12);
    end
  endtask

  // rd_at >= 0 pulses rd_en_i that many clocks after the stop-bit fall
  task automatic send_frame(input bit [7:0] b, input bit bp, input bit bs,
                            input int rd_at, input bit chk_lat, input bit glitch);
    bit p;
    p = (~^b) ^ bp;
    send_bit(0, 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 3));
    send_bit(p, 0);
    ps2_data = ~bs; tick(10);
    ps2_clk = 0;
    if (chk_lat) begin
      tick(FL+3); chk("lat_early", valid_o, 0);
      tick(1);    chk("lat_on", valid_o, 1);
      tick(20-FL-4);
    end else if (rd_at >= 0) begin
      tick(rd_at); rd_en_i = 1; tick(1); rd_en_i = 0;
      tick(20-rd_at-1);
    end else begin
      tick(20);
    end
    ps2_clk = 1; tick(10);
  endtask

  task automatic frame(input bit [7:0] b, input bit bp, input bit bs, input string tag);
    send_frame(b, bp, bs, -1, 0, 0);
    model_frame(b, bp, bs);
    chk_head(tag);
  endtask

  initial begin
    // reset
    tick(5);
    chk_head("rst");
    rst_n = 1; tick(5);

    // single make code with exact latency
    send_frame(8'h1C, 0, 0, -1, 1, 0);
    model_frame(8'h1C, 0, 0);
    chk_head("t1");
    pop("t1_pop");

    // break and extended-break prefixes fold into one entry
    frame(8'hF0, 0, 0, "t2_f0");
    frame(8'h1C, 0, 0, "t2_1c");
    frame(8'hE0, 0, 0, "t2_e0");
    frame(8'hF0, 0, 0, "t2_f0b");
    frame(8'h75, 0, 0, "t2_75");
    pop("t2_pop1");
    pop("t2_pop2");
    pop("t2_pop_empty");

    // parity error, then E0 + bad stop clears ext flag
    frame(8'h1C, 1, 0, "t3_par");
    frame(8'hE0, 0, 0, "t3_e0");
    frame(8'h55, 0, 1, "t3_stop");
    frame(8'h74, 0, 0, "t3_74");
    pop("t3_pop");

    // overflow, in-order drain, clear
    for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0, "t4_fill");
    for (int i = 0; i < 8; i++) pop("t4_drain");
    clr_i = 1; tick(1); clr_i = 0; m_ovf = 0;
    chk_head("t4_clr");
    for (int i = 0; i < 8; i++) frame(8'h11 + 8'(i), 0, 0, "t4_refill");
    send_frame(8'h19, 0, 0, FL+3, 0, 0);
    if (q.size() > 0) void'(q.pop_front());
    model_frame(8'h19, 0, 0);
    chk_head("t4_pushpop");
    for (int i = 0; i < 8; i++) pop("t4_drain2");

    // clock glitch shorter than the filter is rejected
    send_frame(8'hA5, 0, 0, -1, 0, 1);
    model_frame(8'hA5, 0, 0);
    chk_head("t5_glitch");

    // reset mid-frame
    send_bit(0, 0);
    for (int i = 0; i < 4; i++) send_bit(1, 0);
    rst_n = 0; tick(3);
    model_reset();
    chk_head("t5_rst");
    rst_n = 1; tick(3);
    frame(8'h2B, 0, 0, "t5_after");

`ifdef PS2_TIMEOUT_EN
    // stalled frame times out
    send_bit(0, 0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 0);
    tick(TO-19-5);
    chk("t6_pre", n_ferr, exp_ferr);
    tick(10);
    exp_ferr++; m_ext = 0; m_brk = 0;
    chk_head("t6_to");
    frame(8'h1C, 0, 0, "t6_after");
`endif

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      int r;
      bit [7:0] b;
      bit bp, bs;
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 9) == 0);
      frame(b, bp, bs, "rnd");
      if ($urandom_range(0, 2) == 0) pop("rnd_pop");
      if ($urandom_range(0, 9) == 0) begin
        clr_i = 1; tick(1); clr_i = 0; m_ovf = 0;
        chk_head("rnd_clr");
      end
    end
    while (q.size() > 0) pop("rnd_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
